// File: rtl/keccak_perm_ctrl_if.sv
// keccak_perm_ctrl_if: port B memory bus and round-unit link of the Keccak-f[400] sequencer
interface keccak_perm_ctrl_if #(
    parameter int STATE_W = 400
);
    logic [STATE_W-1:0] i_v_b_dout;
    logic [7:0]         i_v_b_dout_ctrl_reg;
    logic [7:0]         i_v_b_dout_ctrl_numOfRounds;
    logic               o_b_wr;
    logic [STATE_W-1:0] o_v_b_din;
    logic [7:0]         o_v_b_din_ctrl_reg;
    logic [STATE_W-1:0] o_v_round_state;
    logic [4:0]         o_v_round_idx;
    logic [STATE_W-1:0] i_v_round_out;
    logic               o_cpu_lock;
    logic               o_busy;
    logic               o_done_irq;

    modport master (
        input  i_v_b_dout, i_v_b_dout_ctrl_reg, i_v_b_dout_ctrl_numOfRounds, i_v_round_out,
        output o_b_wr, o_v_b_din, o_v_b_din_ctrl_reg, o_v_round_state, o_v_round_idx,
        output o_cpu_lock, o_busy, o_done_irq
    );

    modport slave (
        output i_v_b_dout, i_v_b_dout_ctrl_reg, i_v_b_dout_ctrl_numOfRounds, i_v_round_out,
        input  o_b_wr, o_v_b_din, o_v_b_din_ctrl_reg, o_v_round_state, o_v_round_idx,
        input  o_cpu_lock, o_busy, o_done_irq
    );
endinterface

// File: rtl/keccak_perm_ctrl.sv
// keccak_perm_ctrl: runs 1..MAX_ROUNDS Keccak-f[400] rounds on the shared state memory when START is set
module keccak_perm_ctrl #(
    parameter int STATE_W    = 400,
    parameter int MAX_ROUNDS = 20
) (
    input logic               i_common_clk,
    input logic               i_rst_n,
    keccak_perm_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, ROUND, WRITE, DONE} state_t;

    localparam logic [7:0] C_START = 8'h01;
    localparam logic [7:0] C_BUSY  = 8'h02;
    localparam logic [7:0] C_DONE  = 8'h04;
    localparam logic [7:0] C_ERR   = 8'h08;

    state_t             state_q, state_d;
    logic [STATE_W-1:0] work_q, work_d;
    logic [4:0]         idx_q, idx_d, cnt_q, cnt_d;
    logic               err_q, err_d, wr_q, wr_d, lock_q, lock_d, irq_q, irq_d;
    logic [7:0]         nr, ctrl;
    logic               nr_ok;

    assign nr    = bus.i_v_b_dout_ctrl_numOfRounds;
    assign ctrl  = bus.i_v_b_dout_ctrl_reg;
    assign nr_ok = (nr != 8'd0) && (nr <= 8'(MAX_ROUNDS));

    // next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (ctrl[0]) begin
                err_d = !nr_ok;
                if (nr_ok) begin
                    idx_d   = 5'(MAX_ROUNDS) - nr[4:0];
                    cnt_d   = nr[4:0];
                    state_d = LOAD;
                end else begin
                    work_d  = bus.i_v_b_dout;
                    state_d = WRITE;
                end
            end
            LOAD: begin
                work_d  = bus.i_v_b_dout;
                state_d = ROUND;
            end
            ROUND: begin
                work_d  = bus.i_v_round_out;
                cnt_d   = cnt_q - 5'd1;
                idx_d   = (cnt_q == 5'd1) ? idx_q : idx_q + 5'd1;
                state_d = (cnt_q == 5'd1) ? WRITE : ROUND;
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        lock_d = state_d != IDLE;
        wr_d   = (state_d == LOAD) || (state_d == WRITE);
        irq_d  = state_d == DONE;
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge i_common_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            lock_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            lock_q  <= lock_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.o_b_wr             = wr_q;
    assign bus.o_cpu_lock         = lock_q;
    assign bus.o_busy             = lock_q;
    assign bus.o_done_irq         = irq_q;
    assign bus.o_v_round_state    = work_q;
    assign bus.o_v_round_idx      = idx_q;
    assign bus.o_v_b_din          = (state_q == LOAD) ? bus.i_v_b_dout : work_q;
    assign bus.o_v_b_din_ctrl_reg = (state_q == LOAD)  ? ((ctrl & ~C_START) | C_BUSY) :
                                    (state_q != WRITE) ? 8'h00 :
                                    err_q ? ((ctrl & ~(C_START | C_BUSY | C_DONE)) | C_ERR)
                                          : ((ctrl & ~(C_START | C_BUSY | C_ERR)) | C_DONE);
endmodule

// File: tb/tb_keccak_perm_ctrl.sv
// tb_keccak_perm_ctrl: directed bench with a dual-port memory model and a Keccak-f[400] round unit
module tb_keccak_perm_ctrl;
    localparam logic [15:0] RC [20] = '{16'h0001, 16'h8082, 16'h808A, 16'h8000, 16'h808B,
                                        16'h0001, 16'h8081, 16'h8009, 16'h008A, 16'h0088,
                                        16'h8009, 16'h000A, 16'h808B, 16'h008B, 16'h8089,
                                        16'h8003, 16'h8002, 16'h0080, 16'h800A, 16'h000A};
    localparam int RHO [25] = '{0, 1, 14, 12, 11, 4, 12, 6, 7, 4, 3, 10, 11, 9, 7,
                                9, 13, 15, 5, 8, 2, 2, 13, 8, 14};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    logic [399:0] mem_state = '0;
    logic [7:0]   mem_ctrl = 8'h00;
    logic [7:0]   mem_nr = 8'h00;
    logic         cpu_we = 1'b0;
    logic [399:0] cpu_state = '0;
    logic [7:0]   cpu_ctrl = 8'h00;
    logic [7:0]   cpu_nr = 8'h00;

    keccak_perm_ctrl_if #(.STATE_W(400)) bus ();

    keccak_perm_ctrl #(.STATE_W(400), .MAX_ROUNDS(20)) dut (
        .i_common_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [399:0] kround(input logic [399:0] s, input logic [4:0] ri);
        logic [15:0] a [25];
        logic [15:0] b [25];
        logic [15:0] c [5];
        logic [15:0] d [5];
        logic [31:0] t;
        logic [399:0] r;
        for (int i = 0; i < 25; i++) a[i] = s[16*i +: 16];
        for (int x = 0; x < 5; x++) c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
        for (int x = 0; x < 5; x++) begin
            t = {c[(x+1)%5], c[(x+1)%5]} << 1;
            d[x] = c[(x+4)%5] ^ t[31:16];
        end
        for (int i = 0; i < 25; i++) a[i] = a[i] ^ d[i%5];
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) begin
                t = {a[x+5*y], a[x+5*y]} << RHO[x+5*y];
                b[y + 5*((2*x + 3*y) % 5)] = t[31:16];
            end
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                a[x+5*y] = b[x+5*y] ^ (~b[(x+1)%5 + 5*y] & b[(x+2)%5 + 5*y]);
        if (ri < 5'd20) a[0] = a[0] ^ RC[ri];
        for (int i = 0; i < 25; i++) r[16*i +: 16] = a[i];
        return r;
    endfunction

    function automatic logic [399:0] permute(input logic [399:0] s, input int nr);
        logic [399:0] v = s;
        for (int r = 20 - nr; r < 20; r++) v = kround(v, 5'(r));
        return v;
    endfunction

    assign bus.i_v_b_dout                  = mem_state;
    assign bus.i_v_b_dout_ctrl_reg         = mem_ctrl;
    assign bus.i_v_b_dout_ctrl_numOfRounds = mem_nr;
    assign bus.i_v_round_out               = kround(bus.o_v_round_state, bus.o_v_round_idx);

    // memory: port B from the controller, then gated port A from the CPU with priority
    always @(posedge clk) begin
        if (bus.o_b_wr) begin
            mem_state <= bus.o_v_b_din;
            mem_ctrl  <= bus.o_v_b_din_ctrl_reg;
        end
        if (cpu_we && !bus.o_cpu_lock) begin
            mem_state <= cpu_state;
            mem_ctrl  <= cpu_ctrl;
            mem_nr    <= cpu_nr;
        end
    end

    task automatic do_run(input string name, input logic [399:0] init, input logic [7:0] nr,
                          input logic [7:0] ctrl, input logic [7:0] exp_load, input logic [7:0] exp_fin);
        bit err = (nr == 8'd0) || (nr > 8'd20);
        int exp_irq = err ? 2 : int'(nr) + 3;
        int exp_rounds = err ? 0 : int'(nr);
        int exp_wr = err ? 1 : 2;
        logic [399:0] exp_state = err ? init : permute(init, int'(nr));
        int k = 0, irq_at = -1, nlock = 0, nround = 0, nwr = 0;
        bit idx_bad = 0, consec = 0, prev_wr = 0;
        logic [7:0] first_ctrl = 8'hxx, last_ctrl = 8'hxx;
        cpu_we = 1'b1; cpu_state = init; cpu_ctrl = ctrl; cpu_nr = nr;
        @(posedge clk);
        @(negedge clk);
        cpu_we = 1'b0;
        total++;
        if (bus.o_cpu_lock !== 1'b0) begin bad++; $display("FAIL %s lock_cycle0 got=%b exp=0", name, bus.o_cpu_lock); end
        while ((irq_at < 0 || k <= irq_at) && k < 60) begin
            @(negedge clk);
            k++;
            if (bus.o_cpu_lock) nlock++;
            if (bus.o_b_wr) begin
                if (prev_wr) consec = 1;
                if (nwr == 0) first_ctrl = bus.o_v_b_din_ctrl_reg;
                last_ctrl = bus.o_v_b_din_ctrl_reg;
                nwr++;
            end
            prev_wr = bus.o_b_wr;
            if (bus.o_cpu_lock && !bus.o_b_wr && !bus.o_done_irq) begin
                if (int'(bus.o_v_round_idx) != 20 - int'(nr) + nround) idx_bad = 1;
                nround++;
            end
            if (bus.o_done_irq && irq_at < 0) irq_at = k;
        end
        total++;
        if (irq_at !== exp_irq) begin bad++; $display("FAIL %s irq_cycle got=%0d exp=%0d", name, irq_at, exp_irq); end
        total++;
        if (nlock !== exp_irq) begin bad++; $display("FAIL %s lock_cycles got=%0d exp=%0d", name, nlock, exp_irq); end
        total++;
        if (nround !== exp_rounds) begin bad++; $display("FAIL %s round_cycles got=%0d exp=%0d", name, nround, exp_rounds); end
        total++;
        if (idx_bad !== 1'b0) begin bad++; $display("FAIL %s idx_sequence got=bad exp=%0d..19", name, 20 - int'(nr)); end
        total++;
        if (nwr !== exp_wr || consec !== 1'b0) begin bad++; $display("FAIL %s writes got=%0d consec=%0d exp=%0d consec=0", name, nwr, consec, exp_wr); end
        total++;
        if (first_ctrl !== exp_load) begin bad++; $display("FAIL %s first_ctrl got=%h exp=%h", name, first_ctrl, exp_load); end
        total++;
        if (last_ctrl !== exp_fin || mem_ctrl !== exp_fin) begin bad++; $display("FAIL %s final_ctrl got=%h mem=%h exp=%h", name, last_ctrl, mem_ctrl, exp_fin); end
        total++;
        if (mem_state !== exp_state) begin bad++; $display("FAIL %s state got=%h exp=%h", name, mem_state, exp_state); end
        total++;
        if (bus.o_cpu_lock !== 1'b0) begin bad++; $display("FAIL %s lock_after got=%b exp=0", name, bus.o_cpu_lock); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.o_b_wr, bus.o_cpu_lock, bus.o_busy, bus.o_done_irq} !== 4'b0) begin
            bad++; $display("FAIL reset flags got=%b exp=0000", {bus.o_b_wr, bus.o_cpu_lock, bus.o_busy, bus.o_done_irq});
        end
        total++;
        if (bus.o_v_round_state !== '0 || bus.o_v_b_din !== '0 || bus.o_v_b_din_ctrl_reg !== 8'h00 || bus.o_v_round_idx !== 5'd0) begin
            bad++; $display("FAIL reset data got ctrl=%h idx=%0d exp=0", bus.o_v_b_din_ctrl_reg, bus.o_v_round_idx);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_rounds();
        do_run("full20", '0, 8'd20, 8'h01, 8'h02, 8'h04);
    endtask

    task automatic test_single_round();
        do_run("single1", {25{16'hA5C3}} ^ 400'h123456789ABCDEF, 8'd1, 8'h01, 8'h02, 8'h04);
    endtask

    task automatic test_bad_rounds();
        do_run("bad0", {50{8'h3C}}, 8'd0, 8'h01, 8'h08, 8'h08);
        do_run("bad21", {25{16'hBEEF}}, 8'd21, 8'h01, 8'h08, 8'h08);
        do_run("bad255", {100{4'h9}}, 8'd255, 8'h01, 8'h08, 8'h08);
    endtask

    task automatic test_reserved_bits();
        do_run("reserved", {25{16'h0F1E}}, 8'd12, 8'hF1, 8'hF2, 8'hF4);
    endtask

    task automatic test_mid_reset();
        int lk = 0;
        cpu_we = 1'b1; cpu_state = {25{16'h7777}}; cpu_ctrl = 8'h01; cpu_nr = 8'd20;
        @(posedge clk);
        @(negedge clk);
        cpu_we = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (bus.o_v_round_idx !== 5'd3 || bus.o_cpu_lock !== 1'b1) begin
            bad++; $display("FAIL midreset pre idx=%0d lock=%b exp idx=3 lock=1", bus.o_v_round_idx, bus.o_cpu_lock);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.o_b_wr, bus.o_cpu_lock, bus.o_busy, bus.o_done_irq, bus.o_v_round_idx, bus.o_v_b_din_ctrl_reg} !== 17'b0 ||
            bus.o_v_round_state !== '0 || bus.o_v_b_din !== '0) begin
            bad++; $display("FAIL midreset outputs got lock=%b idx=%0d exp=0", bus.o_cpu_lock, bus.o_v_round_idx);
        end
        total++;
        if (mem_ctrl !== 8'h02) begin bad++; $display("FAIL midreset mem_ctrl got=%h exp=02", mem_ctrl); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.o_cpu_lock || bus.o_b_wr) lk++;
        end
        total++;
        if (lk !== 0) begin bad++; $display("FAIL midreset idle got=%0d active_cycles exp=0", lk); end
    endtask

    task automatic test_back_to_back();
        do_run("b2b_first", {25{16'h1357}}, 8'd2, 8'h01, 8'h02, 8'h04);
        do_run("b2b_second", {25{16'h2468}}, 8'd3, 8'h01, 8'h02, 8'h04);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_rounds();
        test_single_round();
        test_bad_rounds();
        test_reserved_bits();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
